// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmitter and the future receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int uart_div(int clk_freq, int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter running 0..DIV-1, tick on the last count of each period.
// Latency: tick is combinational from the count; clear takes effect on the next edge.
// Backpressure: none; clear restarts the period from 0.
module uart_baud_gen #(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap at the end of a period, restart on clear.
  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: pops a FWFT FIFO and serializes each word LSB-first (start, data, [parity], stop).
// Latency: tx falls on the pop edge; frame = (1 + DATA_BITS + P + STOP_BITS) * DIV cycles.
// Backpressure: pops only in IDLE or on the last stop cycle; an empty FIFO leaves the line idle.
// Optional parity bit after the data bits: define UART_TX_PARITY_EN.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] fifo_dout,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(DATA_BITS);

  // Elaboration-time parameter checks.
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx: bit period DIV must be at least 2 clock cycles");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 tx_q, tx_d;
  logic                 pop;
  logic                 clear;
  logic                 tick;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // Period restarts on every state change; held at 0 while idle.
  assign clear = (state_d != state_q) || (state_q == IDLE);

  uart_baud_gen #(
    .DIV (DIV)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  // Next-state, shift and pop decision; tx is derived from the next state so it is registered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    pop        = 1'b0;
    tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d    = PARITY;
`else
            state_d    = STOP;
            stop_idx_d = 1'b0;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            // Last stop cycle: chain straight into the next frame if a word is waiting.
            if (!fifo_empty) begin
              pop = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The word is captured on the same edge the FIFO advances.
    if (pop) begin
      state_d = START;
      shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
      par_d   = (^fifo_dout) ^ 1'(PARITY_ODD);
`endif
    end

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset returns the line to idle high and drops any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign fifo_rd_en = pop && rst_n;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);

endmodule
